// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared widths and FSM state encoding for the parity datapath
package parity_pkg;

  localparam int DATA_WIDTH = 1024;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH;
  localparam int CW         = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/parity_lane_writer.sv
// rtl/parity_lane_writer.sv - one-hot lane write enable and upper-lane zero mask
module parity_lane_writer #(
  parameter int BEATS = 16,
  parameter int LW    = 4
) (
  input  logic [LW-1:0]    idx,
  input  logic             clear_upper,
  output logic [BEATS-1:0] lane_we,
  output logic [BEATS-1:0] lane_clr
);

  always_comb begin
    lane_we  = '0;
    lane_clr = '0;
    for (int j = 0; j < BEATS; j++) begin
      lane_we[j]  = (LW'(j) == idx);
      lane_clr[j] = clear_upper && (LW'(j) > idx);
    end
  end

endmodule

// File: rtl/parity_word_assembler.sv
// rtl/parity_word_assembler.sv - packs 64-bit beats into a held 1024-bit word for the parity stage
module parity_word_assembler
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = parity_pkg::DATA_WIDTH,
  parameter int BEAT_WIDTH = parity_pkg::BEAT_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            s_valid,
  output logic                                            s_ready,
  input  logic [BEAT_WIDTH-1:0]                           s_data,
  input  logic                                            s_last,
  output logic                                            m_valid,
  input  logic                                            m_ready,
  output logic [DATA_WIDTH-1:0]                           m_data,
  output logic [$clog2(DATA_WIDTH/BEAT_WIDTH+1)-1:0]      m_beats,
  output logic                                            m_short,
  output logic [31:0]                                     word_cnt
);

  localparam int NB  = DATA_WIDTH / BEAT_WIDTH;
  localparam int NCW = $clog2(NB + 1);
  localparam int LW  = (NB > 1) ? $clog2(NB) : 1;

  state_t                 state, state_n;
  logic [LW-1:0]          lane_idx, lane_n;
  logic [DATA_WIDTH-1:0]  data_q, data_n;
  logic [NCW-1:0]         beats_q, beats_n;
  logic                   short_q, short_n;
  logic [31:0]            word_cnt_q, cnt_n;

  logic                   take;
  logic                   first;
  logic [LW-1:0]          wr_idx;
  logic                   last_lane;
  logic                   terminate;
  logic [NB-1:0]          lane_we;
  logic [NB-1:0]          lane_clr;

  // A beat outside FILL always begins a fresh word at lane 0 (IDLE, or HOLD on handoff).
  assign first     = (state != FILL);
  assign wr_idx    = first ? '0 : lane_idx;
  assign last_lane = (wr_idx == LW'(NB - 1));
  assign terminate = s_last || last_lane;
  assign take      = s_valid && s_ready;

  parity_lane_writer #(
    .BEATS (NB),
    .LW    (LW)
  ) u_lane_writer (
    .idx         (wr_idx),
    .clear_upper (first || terminate),
    .lane_we     (lane_we),
    .lane_clr    (lane_clr)
  );

  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE, FILL: s_ready = 1'b1;
      HOLD:       s_ready = m_ready;
      default:    s_ready = 1'b0;
    endcase
    if (rst) s_ready = 1'b0;
  end

  always_comb begin
    state_n = state;
    lane_n  = lane_idx;
    data_n  = data_q;
    beats_n = beats_q;
    short_n = short_q;
    cnt_n   = word_cnt_q;

    if (state == HOLD && m_ready) begin
      state_n = IDLE;
      cnt_n   = word_cnt_q + 32'd1;
    end

    if (take) begin
      for (int j = 0; j < NB; j++) begin
        if (lane_we[j]) begin
          data_n[j*BEAT_WIDTH +: BEAT_WIDTH] = s_data;
        end else if (lane_clr[j]) begin
          data_n[j*BEAT_WIDTH +: BEAT_WIDTH] = '0;
        end
      end
      if (terminate) begin
        state_n = HOLD;
        lane_n  = '0;
        beats_n = NCW'(wr_idx) + NCW'(1);
        short_n = !last_lane;
      end else begin
        state_n = FILL;
        lane_n  = wr_idx + LW'(1);
      end
    end

    if (state != IDLE && state != FILL && state != HOLD) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane_idx   <= '0;
      data_q     <= '0;
      beats_q    <= '0;
      short_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state      <= state_n;
      lane_idx   <= lane_n;
      data_q     <= data_n;
      beats_q    <= beats_n;
      short_q    <= short_n;
      word_cnt_q <= cnt_n;
    end
  end

  assign m_valid  = (state == HOLD);
  assign m_data   = data_q;
  assign m_beats  = beats_q;
  assign m_short  = short_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_parity_word_assembler.sv
// tb/tb_parity_word_assembler.sv - randomized and directed checks of the word assembler against a beat-list model
module tb_parity_word_assembler;

  localparam int BW = 64;
  localparam int DW = 1024;
  localparam int NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [4:0]    m_beats;
  logic          m_short;
  logic [31:0]   word_cnt;

  parity_word_assembler dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_beats  (m_beats),
    .m_short  (m_short),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted beats collect in a list; a word closes on s_last or 16 beats.
  logic [BW-1:0] part[$];
  logic [DW-1:0] exp_w[$];
  int            exp_b[$];
  logic [31:0]   model_cnt = '0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] mw;
  logic [DW-1:0] hw;
  int            hb;
  bit            rand_ready = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      part.delete();
      exp_w.delete();
      exp_b.delete();
      model_cnt = '0;
      prev_hold = 1'b0;
    end else begin
      chk("word_cnt", 64'(word_cnt), 64'(model_cnt));
      chk("m_valid_vs_model", 64'(m_valid), 64'(exp_w.size() != 0));
      if (prev_hold) chk("hold_data_stable", 64'(m_data === prev_data), 64'd1);
      if (m_valid) chk("s_ready_in_hold", 64'(s_ready), 64'(m_ready));
      if (m_valid && m_ready && exp_w.size() != 0) begin
        hw = exp_w.pop_front();
        hb = exp_b.pop_front();
        for (int k = 0; k < NB; k++) chk("word_lane", m_data[k*BW +: BW], hw[k*BW +: BW]);
        chk("word_beats", 64'(m_beats), 64'(hb));
        chk("word_short", 64'(m_short), 64'(hb < NB));
        model_cnt = model_cnt + 32'd1;
      end
      if (s_valid && s_ready) begin
        part.push_back(s_data);
        if (s_last || part.size() == NB) begin
          mw = '0;
          foreach (part[k]) mw[k*BW +: BW] = part[k];
          exp_w.push_back(mw);
          exp_b.push_back(part.size());
          part.delete();
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic last);
    int  t;
    bit  acc;
    t   = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = s_ready;
      step();
      t++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      s_last = 1'($urandom_range(0, 1));
      s_data = {$urandom, $urandom};
      step();
    end
    s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    s_valid    = 1'b0;
    while ((exp_w.size() != 0 || m_valid) && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [BW-1:0] words3[NB];
  int            len;
  logic          lst;

  initial begin
    // Reset held three clocks.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data_zero", 64'(m_data != '0), 64'd0);
    chk("rst_m_beats", 64'(m_beats), 64'd0);
    chk("rst_m_short", 64'(m_short), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full word of i+1, consumed immediately.
    m_ready = 1'b1;
    for (int i = 0; i < NB; i++) send_beat(64'(i + 1), 1'b0);
    @(negedge clk);
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    for (int i = 0; i < NB; i++) chk("t1_lane", m_data[i*BW +: BW], 64'(i + 1));
    chk("t1_m_beats", 64'(m_beats), 64'd16);
    chk("t1_m_short", 64'(m_short), 64'd0);
    step();
    @(negedge clk);
    chk("t1_m_valid_drop", 64'(m_valid), 64'd0);
    chk("t1_word_cnt", 64'(word_cnt), 64'd1);
    step();

    // Short word terminated on the third beat.
    m_ready = 1'b0;
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    send_beat(64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
    send_beat(64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
    @(negedge clk);
    chk("t2_lane0", m_data[0 +: BW], 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t2_lane1", m_data[BW +: BW], 64'hBBBB_BBBB_BBBB_BBBB);
    chk("t2_lane2", m_data[2*BW +: BW], 64'hCCCC_CCCC_CCCC_CCCC);
    for (int i = 3; i < NB; i++) chk("t2_upper_zero", m_data[i*BW +: BW], 64'd0);
    chk("t2_m_beats", 64'(m_beats), 64'd3);
    chk("t2_m_short", 64'(m_short), 64'd1);
    drain();

    // Backpressured full word, then handoff with a simultaneous new beat.
    pulse_reset();
    m_ready = 1'b0;
    for (int i = 0; i < NB; i++) begin
      words3[i] = {$urandom, $urandom};
      send_beat(words3[i], 1'b0);
    end
    repeat (5) begin
      @(negedge clk);
      chk("t3_s_ready_low", 64'(s_ready), 64'd0);
      chk("t3_m_valid", 64'(m_valid), 64'd1);
      for (int i = 0; i < NB; i++) chk("t3_lane", m_data[i*BW +: BW], words3[i]);
      step();
    end
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 64'h1234_5678_9ABC_DEF0;
    s_last  = 1'b0;
    @(negedge clk);
    chk("t3_s_ready_bubble_free", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t3_word_cnt", 64'(word_cnt), 64'd1);
    chk("t3_m_valid_after", 64'(m_valid), 64'd0);
    step();
    send_beat(64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    drain();

    // 40 random-length words with random gaps and backpressure.
    pulse_reset();
    rand_ready = 1'b1;
    for (int w = 0; w < 40; w++) begin
      len = $urandom_range(1, NB);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if (b != len - 1) lst = 1'b0;
        else if (len == NB) lst = 1'($urandom_range(0, 1));
        else lst = 1'b1;
        send_beat({$urandom, $urandom}, lst);
      end
    end
    drain();
    @(negedge clk);
    chk("t4_word_cnt", 64'(word_cnt), 64'd40);
    step();

    // Reset mid-word discards the partial word.
    pulse_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_beat({$urandom, $urandom}, 1'b0);
    pulse_reset();
    @(negedge clk);
    chk("t5_no_m_valid", 64'(m_valid), 64'd0);
    step();
    for (int i = 0; i < NB; i++) send_beat(64'(100 + i), 1'b0);
    @(negedge clk);
    chk("t5_m_beats", 64'(m_beats), 64'd16);
    for (int i = 0; i < NB; i++) chk("t5_lane", m_data[i*BW +: BW], 64'(100 + i));
    drain();
    @(negedge clk);
    chk("t5_word_cnt", 64'(word_cnt), 64'd1);
    step();

    // Counter wrap.
    pulse_reset();
    dut.word_cnt_q = 32'hFFFF_FFFF;
    model_cnt      = 32'hFFFF_FFFF;
    m_ready = 1'b1;
    send_beat(64'hDEAD_BEEF_0000_0001, 1'b1);
    drain();
    @(negedge clk);
    chk("t6_word_cnt_wrap", 64'(word_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
